matrix_mac_stream: RTL and testbench

Sequential, streaming counterpart to the combinational flattened-bus matrix multiplier. Elements of A (MxN) and B (NxP) arrive serially on a valid/ready input stream, in signed fixed point. The block stores both matrices and computes Y = A*B with a single MAC, one MAC per cycle. It streams Y out row-major on a valid/ready output stream. It is the serial producer/consumer side used where the full flattened buses are too wide to route.

---
 rtl/matrix_mac_stream.sv | 184 ++++++++++++++++++
 tb/tb_matrix_mac_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_stream.sv
// Streaming matrix multiplier: loads A (MxN) then B (NxP) element by element,
// then computes Y = A*B with one MAC per cycle and streams Y out row-major.
module matrix_mac_stream #(
  parameter int M           = 4,
  parameter int N           = 3,
  parameter int P           = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_sat,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int DW  = DATA_WIDTH;
  localparam int AW  = 2 * DW + $clog2(N) + 1;
  localparam int AAW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int BAW = (N * P > 1) ? $clog2(N * P) : 1;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [AAW-1:0] A_LAST     = AAW'(M * N - 1);
  localparam logic [AAW-1:0] A_ROW_STEP = AAW'(N);
  localparam logic [AAW-1:0] ROW_LAST   = AAW'((M - 1) * N);
  localparam logic [BAW-1:0] B_LAST     = BAW'(N * P - 1);
  localparam logic [BAW-1:0] B_STEP     = BAW'(P);
  localparam logic [BAW-1:0] COL_LAST   = BAW'(P - 1);
  localparam logic [KW-1:0]  K_LAST     = KW'(N - 1);

  typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_COMPUTE, S_OUT} state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DW-1:0]         r_out_data;
  logic                  r_out_last;
  logic                  r_out_sat;
  logic                  r_busy;
  // Address registers double as load counters and as running MAC indices:
  // r_a_row = i*N, r_b_col = j, r_a_addr = i*N+k, r_b_addr = k*P+j.
  logic [AAW-1:0]        r_a_addr;
  logic [AAW-1:0]        r_a_row;
  logic [BAW-1:0]        r_b_addr;
  logic [BAW-1:0]        r_b_col;
  logic [KW-1:0]         r_k;
  logic signed [AW-1:0]  r_acc;

  logic signed [DW-1:0]  r_a [M*N];
  logic signed [DW-1:0]  r_b [N*P];

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_shift;
  logic                  w_ovf;
  logic [DW-1:0]         w_sat_val;
  logic [DW-1:0]         w_result;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  assign w_prod  = r_a[r_a_addr] * r_b[r_b_addr];
  assign w_sum   = r_acc + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_shift = w_sum >>> FRACT_WIDTH;

  // Result fits only if every bit above the DW-1 sign position equals the sign.
  assign w_ovf     = !((&w_shift[AW-1:DW-1]) || !(|w_shift[AW-1:DW-1]));
  assign w_sat_val = w_shift[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  assign w_result  = w_ovf ? w_sat_val : w_shift[DW-1:0];

  always_ff @(posedge clk) begin
    if (w_in_fire && r_state == S_LOAD_A) r_a[r_a_addr] <= in_data;
    if (w_in_fire && r_state == S_LOAD_B) r_b[r_b_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD_A;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
      r_busy      <= 1'b0;
      r_a_addr    <= '0;
      r_a_row     <= '0;
      r_b_addr    <= '0;
      r_b_col     <= '0;
      r_k         <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        S_LOAD_A: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_busy <= 1'b1;
            if (r_a_addr == A_LAST) begin
              r_a_addr <= '0;
              r_state  <= S_LOAD_B;
            end else begin
              r_a_addr <= r_a_addr + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (w_in_fire) begin
            if (r_b_addr == B_LAST) begin
              r_in_ready <= 1'b0;
              r_state    <= S_COMPUTE;
              r_a_addr   <= '0;
              r_a_row    <= '0;
              r_b_addr   <= '0;
              r_b_col    <= '0;
              r_k        <= '0;
              r_acc      <= '0;
            end else begin
              r_b_addr <= r_b_addr + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (r_k == K_LAST) begin
            r_out_data  <= w_result;
            r_out_sat   <= w_ovf;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_a_row == ROW_LAST) && (r_b_col == COL_LAST);
            r_state     <= S_OUT;
          end else begin
            r_acc    <= w_sum;
            r_k      <= r_k + 1'b1;
            r_a_addr <= r_a_addr + 1'b1;
            r_b_addr <= r_b_addr + B_STEP;
          end
        end
        S_OUT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_out_last <= 1'b0;
              r_state    <= S_LOAD_A;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_a_addr   <= '0;
              r_b_addr   <= '0;
            end else begin
              r_acc   <= '0;
              r_k     <= '0;
              r_state <= S_COMPUTE;
              if (r_b_col == COL_LAST) begin
                r_b_col  <= '0;
                r_b_addr <= '0;
                r_a_row  <= r_a_row + A_ROW_STEP;
                r_a_addr <= r_a_row + A_ROW_STEP;
              end else begin
                r_b_col  <= r_b_col + 1'b1;
                r_b_addr <= r_b_col + 1'b1;
                r_a_addr <= r_a_row;
              end
            end
          end
        end
        default: r_state <= S_LOAD_A;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sat   = r_out_sat;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_matrix_mac_stream.sv
// Directed bench for matrix_mac_stream: expected Y elements are queued at
// stimulus time and a negedge monitor pops and compares on each output handshake.
module tb_matrix_mac_stream;

  localparam int M  = 4;
  localparam int N  = 3;
  localparam int P  = 5;
  localparam int DW = 16;

  // Handshake: a transfer happens at a rising edge where valid and ready are both 1.
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_sat;
  logic          busy;
  logic [1:0]    dbg_state;

  matrix_mac_stream #(.M(M), .N(N), .P(P), .DATA_WIDTH(DW), .FRACT_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];   // {last, sat, data}
  logic [17:0] exp_item;
  logic [17:0] held;
  bit          hold_pending = 0;
  int          out_idx = 0;
  int          rdy_mode = 0;
  int          stall_cnt = 0;
  bit          junk_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- output ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (out_valid && out_idx == 7 && stall_cnt < 5) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) hold_pending = 0;
    else begin
      if (hold_pending) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_last, out_sat, out_data}, held);
        hold_pending = 0;
      end
      if (out_valid) begin
        check("in_ready_low_during_out", in_ready, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h, expected no output", out_data);
          end else begin
            exp_item = exp_q.pop_front();
            check($sformatf("y%0d_data", out_idx), out_data, exp_item[15:0]);
            check($sformatf("y%0d_sat", out_idx), out_sat, exp_item[16]);
            check($sformatf("y%0d_last", out_idx), out_last, exp_item[17]);
          end
          out_idx = out_last ? 0 : out_idx + 1;
        end else begin
          hold_pending = 1;
          held = {out_last, out_sat, out_data};
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] d, input bit gap);
    int t;
    if (gap) repeat ($urandom_range(1, 3)) tick();
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b, expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic load(input logic [DW-1:0] a_even, input logic [DW-1:0] a_odd,
                      input logic [DW-1:0] b_val, input bit gap);
    for (int i = 0; i < M * N; i++) send((i % 2 == 0) ? a_even : a_odd, gap);
    for (int i = 0; i < N * P; i++) send(b_val, gap);
  endtask

  task automatic push_rows(input logic [DW-1:0] even_row, input logic [DW-1:0] odd_row,
                           input bit sat);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < P; c++)
        exp_q.push_back({1'(r == M - 1 && c == P - 1), sat, (r % 2 == 0) ? even_row : odd_row});
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      if (junk_mode) begin
        in_valid = (exp_q.size() > 1);
        in_data  = 16'($urandom);
      end
      tick();
      t++;
    end
    in_valid = 1'b0;
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_in_ready_idle"}, in_ready, 1);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", in_ready, 1);
    check("busy_after_reset", busy, 0);

    // all 1.0 -> 3.0, plus latency from final B handshake
    push_rows(16'h0300, 16'h0300, 1'b0);
    load(16'h0100, 16'h0100, 16'h0100, 1'b0);
    check("in_ready_drop_after_load", in_ready, 0);
    check("busy_after_load", busy, 1);
    check("state_compute", dbg_state, 2);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("first_out_latency", lat, N);
    drain("ones");

    push_rows(16'h0400, 16'hFF00, 1'b0);
    load(16'h0300, 16'hFE00, 16'h0100, 1'b0);
    drain("alt_rows");

    push_rows(16'h7FFF, 16'h7FFF, 1'b1);
    load(16'h7F00, 16'h7F00, 16'h7F00, 1'b0);
    drain("sat_pos");

    push_rows(16'h8000, 16'h8000, 1'b1);
    load(16'h8000, 16'h8000, 16'h7F00, 1'b0);
    drain("sat_neg");

    push_rows(16'h0000, 16'h0000, 1'b0);
    load(16'h0001, 16'h0001, 16'h0001, 1'b0);
    drain("trunc_pos");

    push_rows(16'hFFFF, 16'hFFFF, 1'b0);
    load(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
    drain("trunc_neg");

    // backpressure, input gaps, ignored in_valid while computing
    stall_cnt = 0;
    rdy_mode  = 1;
    junk_mode = 1;
    push_rows(16'h0400, 16'hFF00, 1'b0);
    load(16'h0300, 16'hFE00, 16'h0100, 1'b1);
    drain("backpressure");
    check("stall_cycles_on_y7", stall_cnt, 5);
    junk_mode = 0;
    rdy_mode  = 0;

    // asynchronous reset in the middle of COMPUTE
    load(16'h0100, 16'h0100, 16'h0100, 1'b0);
    tick();
    check("busy_before_midreset", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_busy", busy, 0);
    #3;
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready_release", in_ready, 1);
    push_rows(16'h0300, 16'h0300, 1'b0);
    load(16'h0100, 16'h0100, 16'h0100, 1'b0);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
